fetch_ctrl: RTL

//  Instruction-fetch sequencer for the pipelined MIPS core. Owns the architectural PC register
//  and computes the next PC (sequential, branch, J, JR). Drives a req/ack instruction-memory

---
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the architectural PC and
//               computes the next PC: sequential, branch, J or JR. It drives a
//               req/ack instruction-memory port and buffers one fetched
//               instruction for the IF/ID stage. Redirects squash any buffered
//               or in-flight fetch, and there is no delay slot.
// Ports       :
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous active-high reset
//   stall          in   1   IF/ID not ready; the buffered instruction is held
//   redirect_valid in   1   decode requests a control-flow change
//   redirect_op    in   2   0 none, 1 BRANCH, 2 J, 3 JR
//   redirect_pc    in   32  PC of the control instruction
//   redirect_imm   in   32  branch word offset / jump index / JR register
//   imem_req       out  1   fetch request, held until imem_ack
//   imem_addr      out  32  fetch address, stable while imem_req=1
//   imem_ack       in   1   imem_rdata is valid this cycle
//   imem_rdata     in   32  instruction word
//   if_valid       out  1   if_pc/if_instr hold a valid instruction
//   if_pc          out  32  PC of the buffered instruction
//   if_instr       out  32  buffered instruction
//   misalign       out  1   sticky flag: a JR target was not word aligned
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_op,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign
);

  localparam logic [1:0] c_OP_NONE   = 2'd0;
  localparam logic [1:0] c_OP_BRANCH = 2'd1;
  localparam logic [1:0] c_OP_J      = 2'd2;
  localparam logic [1:0] c_OP_JR     = 2'd3;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;   // address of a squashed request still awaiting ack
  logic        imem_req_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        misalign_q;

  logic        w_redir;
  logic [31:0] w_tgt;
  logic        w_jr_misalign;

  // An op code of zero means the redirect strobe carries no request.
  assign w_redir = redirect_valid && (redirect_op != c_OP_NONE);

  always_comb begin
    w_tgt = pc_q;
    unique case (redirect_op)
      c_OP_BRANCH: w_tgt = redirect_pc + 32'd4 + {redirect_imm[29:0], 2'b00};
      c_OP_J:      w_tgt = {redirect_pc[31:28], redirect_imm[25:0], 2'b00};
      c_OP_JR:     w_tgt = {redirect_imm[31:2], 2'b00};
      default:     w_tgt = pc_q;
    endcase
  end

  assign w_jr_misalign = w_redir && (redirect_op == c_OP_JR) &&
                         (redirect_imm[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'd0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      // BOOT ignores redirects, so the flag only follows accepted JR targets.
      if (w_jr_misalign && (state_q != BOOT)) begin
        misalign_q <= 1'b1;
      end

      unique case (state_q)
        BOOT: begin
          // A stale ack from a request cut off by reset is ignored here.
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end

        FETCH: begin
          if (w_redir) begin
            pc_q <= w_tgt;
            if (!imem_ack) begin
              // The old request stays on the bus until it is acknowledged.
              pend_pc_q <= pc_q;
              state_q   <= DRAIN;
            end
          end else if (imem_ack) begin
            if_instr_q <= imem_rdata;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_q + 32'd4;
            imem_req_q <= 1'b0;
            state_q    <= HOLD;
          end
        end

        HOLD: begin
          if (w_redir) begin
            if_valid_q <= 1'b0;
            pc_q       <= w_tgt;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end else if (!stall) begin
            if_valid_q <= 1'b0;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end
        end

        DRAIN: begin
          // The last redirect wins, even when it arrives together with the ack.
          if (w_redir) begin
            pc_q <= w_tgt;
          end
          if (imem_ack) begin
            state_q <= FETCH;
          end
        end

        default: begin
          state_q    <= BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = (state_q == DRAIN) ? pend_pc_q : pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign misalign  = misalign_q;

endmodule
`default_nettype wire
